// File: rtl/aq_hpcp_cntof_bank.sv
// aq_hpcp_cntof_bank
// Sticky overflow status bank for the HPCP counters: captures per-channel
// overflow pulses, offers write/set/clear software access, tracks overflows
// that arrived on a flag software had not yet serviced, and raises a maskable
// interrupt request (level or pulse) plus a lowest-index pending channel.
module aq_hpcp_cntof_bank #(
  parameter int CNT_NUM  = 32,
  parameter int INT_MODE = 0,
  localparam int IDX_W   = (CNT_NUM > 1) ? $clog2(CNT_NUM) : 1
) (
  input  logic               hpcp_clk,
  input  logic               cpurst,
  input  logic [CNT_NUM-1:0] counter_overflow,
  input  logic               cntof_wen,
  input  logic [1:0]         cntof_wop,
  input  logic [CNT_NUM-1:0] cntof_wdata,
  input  logic               inten_wen,
  input  logic [CNT_NUM-1:0] inten_wdata,
  output logic [CNT_NUM-1:0] cntof,
  output logic [CNT_NUM-1:0] cntof_lost,
  output logic [CNT_NUM-1:0] inten,
  output logic               hpcp_int_req,
  output logic               ovf_idx_vld,
  output logic [IDX_W-1:0]   ovf_idx
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  logic [CNT_NUM-1:0] cntof_q, cntof_d;
  logic [CNT_NUM-1:0] lost_q,  lost_d;
  logic [CNT_NUM-1:0] inten_q, inten_d;
  logic               int_q,   int_d;

  logic [CNT_NUM-1:0] sw;
  logic [CNT_NUM-1:0] lost_set;
  logic [CNT_NUM-1:0] lost_clr;
  logic [CNT_NUM-1:0] pend_new;
  logic [CNT_NUM-1:0] pend_old;
  logic [CNT_NUM-1:0] active;

  // Software view of the flag vector after this cycle's CSR access.
  always_comb begin
    sw = cntof_q;
    if (cntof_wen) begin
      case (cntof_wop)
        OP_WRITE: sw = cntof_wdata;
        OP_SET:   sw = cntof_q | cntof_wdata;
        OP_CLEAR: sw = cntof_q & ~cntof_wdata;
        default:  sw = cntof_q;
      endcase
    end
  end

  // Next-state flags, lost flags and enables; hardware overflow always wins
  // over a software clear so that no event is dropped.
  always_comb begin
    cntof_d  = sw | counter_overflow;
    // An overflow landing on a flag that stays set after the access is lost.
    lost_set = counter_overflow & cntof_q & sw;
    // Software acknowledging a flag (1 -> 0) also acknowledges its loss.
    lost_clr = {CNT_NUM{cntof_wen}} & cntof_q & ~sw;
    lost_d   = lost_set | (lost_q & ~lost_clr);
    inten_d  = inten_wen ? inten_wdata : inten_q;
  end

  // Interrupt request computed from next-state values so it tracks the flags
  // with no extra cycle of latency.
  always_comb begin
    pend_new = cntof_d & inten_d;
    pend_old = cntof_q & inten_q;
    if (INT_MODE == 1) begin
      int_d = |(pend_new & ~pend_old);
    end else begin
      int_d = |pend_new;
    end
  end

  // State registers; reset discards every pending flag and request.
  always_ff @(posedge hpcp_clk) begin
    if (cpurst) begin
      cntof_q <= '0;
      lost_q  <= '0;
      inten_q <= '0;
      int_q   <= 1'b0;
    end else begin
      cntof_q <= cntof_d;
      lost_q  <= lost_d;
      inten_q <= inten_d;
      int_q   <= int_d;
    end
  end

  // Lowest-index priority encode of the enabled, set flags.
  always_comb begin
    active      = cntof_q & inten_q;
    ovf_idx_vld = |active;
    ovf_idx     = '0;
    for (int i = CNT_NUM - 1; i >= 0; i--) begin
      if (active[i]) begin
        ovf_idx = IDX_W'(i);
      end
    end
  end

  assign cntof        = cntof_q;
  assign cntof_lost   = lost_q;
  assign inten        = inten_q;
  assign hpcp_int_req = int_q;

endmodule
